// File: rtl/smem_blit_ctrl.sv
// rtl/smem_blit_ctrl.sv - screen memory port mux with fill/scroll blit engine
// CPU accesses always own the port; the engine advances only on cycles without cpu_sel.
module smem_blit_ctrl #(
  parameter int Nloc  = 1200,
  parameter int Ncols = 40,
  parameter int Dbits = 4,
  localparam int Aw   = $clog2(Nloc)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_sel,
  input  logic             cpu_wr,
  input  logic [Aw-1:0]    cpu_addr,
  input  logic [Dbits-1:0] cpu_wdata,
  output logic [Dbits-1:0] cpu_rdata,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [Dbits-1:0] cmd_data,
  output logic             cmd_ready,
  output logic             busy,
  output logic             done,
  output logic             smem_wr,
  output logic [Aw-1:0]    smem_addr,
  output logic [Dbits-1:0] smem_wdata,
  input  logic [Dbits-1:0] smem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SCR_RD,
    S_SCR_WR,
    S_SCR_FILL,
    S_DONE
  } state_t;

  localparam logic [Aw-1:0] LAST_CELL   = Aw'(Nloc - 1);
  localparam logic [Aw-1:0] LAST_MOVED  = Aw'(Nloc - Ncols - 1);
  localparam logic [Aw-1:0] FIRST_BLANK = Aw'(Nloc - Ncols);
  localparam logic [Aw-1:0] ROW_STEP    = Aw'(Ncols);

  state_t           state, state_n;
  logic [Aw-1:0]    a, a_n;
  logic [Dbits-1:0] cap, cap_n;
  logic [Dbits-1:0] fill_char, fill_char_n;

  logic             eng_wr;
  logic [Aw-1:0]    eng_addr;
  logic [Dbits-1:0] eng_wdata;
  logic             advance;

  // IDLE and DONE never touch the port, so only the memory-walking states stall.
  assign advance = !cpu_sel || (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a         <= '0;
      cap       <= '0;
      fill_char <= '0;
    end else if (advance) begin
      state     <= state_n;
      a         <= a_n;
      cap       <= cap_n;
      fill_char <= fill_char_n;
    end
  end

  always_comb begin
    state_n     = state;
    a_n         = a;
    cap_n       = cap;
    fill_char_n = fill_char;
    eng_wr      = 1'b0;
    eng_addr    = '0;
    eng_wdata   = '0;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          fill_char_n = cmd_data;
          a_n         = '0;
          case (cmd_op)
            2'b00:   state_n = S_FILL;
            2'b01:   state_n = S_SCR_RD;
            default: state_n = S_DONE;
          endcase
        end
      end
      S_FILL, S_SCR_FILL: begin
        busy      = 1'b1;
        eng_wr    = 1'b1;
        eng_addr  = a;
        eng_wdata = fill_char;
        if (a == LAST_CELL) begin
          state_n = S_DONE;
        end else begin
          a_n = a + 1'b1;
        end
      end
      S_SCR_RD: begin
        busy     = 1'b1;
        eng_addr = a + ROW_STEP;
        cap_n    = smem_rdata;
        state_n  = S_SCR_WR;
      end
      S_SCR_WR: begin
        busy      = 1'b1;
        eng_wr    = 1'b1;
        eng_addr  = a;
        eng_wdata = cap;
        if (a == LAST_MOVED) begin
          a_n     = FIRST_BLANK;
          state_n = S_SCR_FILL;
        end else begin
          a_n     = a + 1'b1;
          state_n = S_SCR_RD;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign smem_addr  = cpu_sel ? cpu_addr  : eng_addr;
  assign smem_wr    = cpu_sel ? cpu_wr    : eng_wr;
  assign smem_wdata = cpu_sel ? cpu_wdata : eng_wdata;
  assign cpu_rdata  = smem_rdata;

endmodule
